// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU_7bit between two valid/ready requesters.
// One operation in flight: capture operands, hold them ALU_LAT cycles, register result/ZF, hand back.
module alu_share_arbiter #(
    parameter int W       = 7,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [1:0]     req_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zf,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zf,
    output logic           busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic         alu_op_q, alu_op_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_result_q, rsp_result_d;
    logic         rsp_zf_q, rsp_zf_d;

    logic         winner;
    logic         accept;

    // Tie goes to whichever port did not win last; ready is masked while reset is asserted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner    = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b10) begin
            winner = 1'b1;
        end else if (req_valid == 2'b11) begin
            winner = ~last_grant_q;
        end
        if ((state_q == S_IDLE) && reset && (req_valid != 2'b00)) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zf_d     = rsp_zf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d      = winner ? req_a[2*W-1:W] : req_a[W-1:0];
                    alu_b_d      = winner ? req_b[2*W-1:W] : req_b[W-1:0];
                    alu_op_d     = req_op[winner];
                    last_grant_d = winner;
                    cnt_d        = 4'd0;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_LAST) begin
                    rsp_result_d = alu_result;
                    rsp_zf_d     = alu_zf;
                    rsp_valid_d  = last_grant_q ? 2'b10 : 2'b01;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[last_grant_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zf_q     <= rsp_zf_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zf     = rsp_zf_q;
    assign busy       = (state_q == S_EXEC) || (state_q == S_RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, scoreboard queue of hand-computed responses,
// and a negedge monitor that pops and compares on every response handshake.
module tb_alu_share_arbiter;

    localparam int W = 7;

    typedef struct packed {
        logic         port;
        logic [W-1:0] res;
        logic         zf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
    } op_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_zf;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_zf;
    logic           busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    op_t  q0[$];
    op_t  q1[$];
    exp_t mon_e;

    alu_share_arbiter #(.W(W), .ALU_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zf     (alu_zf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zf     (rsp_zf),
        .busy       (busy)
    );

    // Stand-in for ALU_7bit: add/subtract modulo 2^W, ZF from the result.
    assign alu_result = alu_op ? W'(alu_a - alu_b) : W'(alu_a + alu_b);
    assign alu_zf     = (alu_result == '0);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b result=%0d with empty scoreboard", rsp_valid, rsp_result);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_port", 32'(rsp_valid), mon_e.port ? 32'd2 : 32'd1);
                check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
                check("rsp_zf", 32'(rsp_zf), 32'(mon_e.zf));
            end
        end
    end

    task automatic set_port(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        if (p == 0) begin
            req_a[W-1:0] = a;
            req_b[W-1:0] = b;
            req_op[0]    = op;
        end else begin
            req_a[2*W-1:W] = a;
            req_b[2*W-1:W] = b;
            req_op[1]      = op;
        end
    endtask

    task automatic wait_ready(input int p);
        int n = 0;
        @(negedge clk);
        while (!req_ready[p] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready[p]), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Keeps each port's front operation presented until its handshake, then advances.
    task automatic run_ops();
        int         guard = 0;
        logic [1:0] hs;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 300) begin
            req_valid[0] = (q0.size() > 0);
            req_valid[1] = (q1.size() > 0);
            if (q0.size() > 0) set_port(0, q0[0].a, q0[0].b, q0[0].op);
            if (q1.size() > 0) set_port(1, q1[0].a, q1[0].b, q1[0].op);
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (hs[0]) void'(q0.pop_front());
            if (hs[1]) void'(q1.pop_front());
            guard++;
        end
        req_valid = 2'b00;
        check("drive_done", 32'(q0.size() + q1.size()), 32'd0);
        wait_drain();
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = 2'b00;
        rsp_ready = 2'b11;
        set_port(0, 7'd4, 7'd4, 1'b0);
        set_port(1, 7'd6, 7'd6, 1'b0);

        // Reset state while both requesters are waving valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset held 3 cycles mid-EXEC drops the operation
        req_valid = 2'b01;
        set_port(0, 7'd9, 7'd1, 1'b0);
        wait_ready(0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("exec_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("drop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("drop_rsp_result", 32'(rsp_result), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Tie after reset: req0 wins first
        q0.push_back('{a: 7'd2,   b: 7'd2,  op: 1'b1});
        q1.push_back('{a: 7'd100, b: 7'd27, op: 1'b0});
        sb.push_back('{port: 1'b0, res: 7'd0,   zf: 1'b1});
        sb.push_back('{port: 1'b1, res: 7'd127, zf: 1'b0});
        run_ops();

        // req0 only, 5+3: latency and return to IDLE, then a back-to-back 60-4
        sb.push_back('{port: 1'b0, res: 7'd8,  zf: 1'b0});
        sb.push_back('{port: 1'b0, res: 7'd56, zf: 1'b0});
        req_valid = 2'b01;
        set_port(0, 7'd5, 7'd3, 1'b0);
        wait_ready(0);
        @(posedge clk);
        #1;
        set_port(0, 7'd60, 7'd4, 1'b1);
        @(negedge clk);
        check("t2_exec_busy", 32'(busy), 32'd1);
        check("t2_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t2_exec_req_ready", 32'(req_ready), 32'd0);
        check("t2_exec_alu_a", 32'(alu_a), 32'd5);
        @(negedge clk);
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp_alu_hold", 32'({alu_a, alu_b, alu_op}), 32'({7'd5, 7'd3, 1'b0}));
        @(negedge clk);
        check("t2_idle_busy", 32'(busy), 32'd0);
        check("t2_idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_drain();

        // req1 only, 9-9 gives zero with ZF
        q1.push_back('{a: 7'd9, b: 7'd9, op: 1'b1});
        sb.push_back('{port: 1'b1, res: 7'd0, zf: 1'b1});
        run_ops();

        // Modulo wrap both ways
        q1.push_back('{a: 7'd100, b: 7'd50, op: 1'b0});
        q1.push_back('{a: 7'd3,   b: 7'd5,  op: 1'b1});
        sb.push_back('{port: 1'b1, res: 7'd22,  zf: 1'b0});
        sb.push_back('{port: 1'b1, res: 7'd126, zf: 1'b0});
        run_ops();

        // Both continuously valid: grants alternate 0,1,0,1,0,1
        q0.push_back('{a: 7'd10,  b: 7'd20, op: 1'b0});
        q0.push_back('{a: 7'd64,  b: 7'd64, op: 1'b0});
        q0.push_back('{a: 7'd7,   b: 7'd2,  op: 1'b1});
        q1.push_back('{a: 7'd50,  b: 7'd25, op: 1'b1});
        q1.push_back('{a: 7'd1,   b: 7'd2,  op: 1'b0});
        q1.push_back('{a: 7'd127, b: 7'd1,  op: 1'b0});
        sb.push_back('{port: 1'b0, res: 7'd30, zf: 1'b0});
        sb.push_back('{port: 1'b1, res: 7'd25, zf: 1'b0});
        sb.push_back('{port: 1'b0, res: 7'd0,  zf: 1'b1});
        sb.push_back('{port: 1'b1, res: 7'd3,  zf: 1'b0});
        sb.push_back('{port: 1'b0, res: 7'd5,  zf: 1'b0});
        sb.push_back('{port: 1'b1, res: 7'd0,  zf: 1'b1});
        run_ops();

        // Response back-pressure; only the non-granted port says ready meanwhile
        sb.push_back('{port: 1'b0, res: 7'd13, zf: 1'b0});
        sb.push_back('{port: 1'b1, res: 7'd2,  zf: 1'b0});
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        set_port(0, 7'd20, 7'd7, 1'b1);
        wait_ready(0);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        set_port(1, 7'd1, 7'd1, 1'b0);
        n = 0;
        @(negedge clk);
        while (rsp_valid == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'd13);
            check("bp_rsp_zf", 32'(rsp_zf), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        wait_ready(1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
